pipelined_adder_n_bit: RTL and testbench
========================================

PIPELINED_ADDER_N_BIT -- requirements
Module: pipelined_adder_n_bit

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter SEG_WIDTH, default 8: bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG_WIDTH, and STAGES = WIDTH/SEG_WIDTH.
REQ-003 clk  input  1  single clock for all state; rising-edge triggered.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  a, b, cin and sub carry a new operation.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 cin  input  1  carry-in; used only when sub=0.
REQ-009 sub  input  1  mode: 0 = a+b+cin, 1 = a-b (a + ~b + 1).
REQ-010 out_valid  output  1  sum, cout and overflow hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  raw carry out of the MSB.
REQ-014 overflow  output  1  two's-complement signed overflow.

Function
REQ-015 Transfer in: an operation SHALL be accepted when in_valid && in_ready. Transfer out: a result SHALL be consumed when out_valid && out_ready.
REQ-016 Global advance enable adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-017 When adv=0, every pipeline register SHALL hold its value, and sum/cout/overflow/out_valid SHALL remain stable.
REQ-018 Stage s (0..STAGES-1) SHALL add segment s of a and b_eff (b_eff = sub ? ~b : b) together with the registered carry from stage s-1; stage 0 SHALL use carry-in = sub ? 1 : cin.
REQ-019 Upper operand segments SHALL be delayed through skew registers so that segment s reaches its adder exactly s cycles after acceptance; lower sum segments SHALL be deskewed so that all WIDTH bits appear together.
REQ-020 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when adv remains 1; throughput SHALL be one operation per cycle.
REQ-021 A valid bit SHALL travel with each stage; bubbles (in_valid=0) SHALL propagate as invalid slots and SHALL NOT produce out_valid.
REQ-022 cout SHALL be the carry out of bit WIDTH-1; overflow SHALL equal carry-into-MSB XOR cout.
REQ-023 Results SHALL leave the block in acceptance order; no operation SHALL be lost or duplicated under any out_ready pattern.
REQ-024 Accepting a new input and consuming the output in the same cycle SHALL be legal and SHALL advance the pipeline by one stage.
REQ-025 With STAGES=1 the block SHALL behave as a single registered adder with latency 1.

Reset
REQ-026 While rst=1, all valid bits, out_valid, sum, cout and overflow SHALL be 0 immediately, without waiting for a clock edge.
REQ-027 Operations in flight when reset asserts SHALL be discarded; none SHALL emerge after reset is released.
REQ-028 in_ready SHALL be 1 during the first cycle after reset is deasserted.

Structure
REQ-029 Package adder_pkg SHALL hold the default WIDTH and SEG_WIDTH, and the STAGES derivation function.
REQ-030 Sub-module adder_segment SHALL implement one SEG_WIDTH-bit stage: combinational add, with the sum segment, carry and valid bit registered under adv. The top SHALL instantiate it STAGES times in a generate loop.
REQ-031 An elaboration-time check SHALL reject any WIDTH that is not a multiple of SEG_WIDTH.

Verification (WIDTH=32, SEG_WIDTH=8, out_ready=1 unless stated)
REQ-032 Apply a=FFFFFFFF, b=00000001, cin=0, sub=0. The result SHALL appear 4 cycles later as sum=00000000, cout=1, overflow=0.
REQ-033 Apply a=7FFFFFFF, b=00000001, sub=0. The result SHALL be sum=80000000, cout=0, overflow=1.
REQ-034 Apply a=00000005, b=00000007, sub=1, cin=1. The result SHALL be sum=FFFFFFFE, cout=0, overflow=0, with cin ignored.
REQ-035 Issue 8 back-to-back operations a=i, b=i, with out_ready held 0 from the first out_valid for 5 cycles. in_ready SHALL stay 0 while stalled, outputs SHALL be 2i in order, and no result SHALL be lost.
REQ-036 Assert rst asynchronously mid-cycle with 3 operations in flight. out_valid SHALL drop to 0 before the next clock edge, and zero results SHALL appear after release.
REQ-037 Re-elaborate with WIDTH=16, SEG_WIDTH=16 and apply a=1234, b=4321. The result SHALL be sum=5555 after 1 cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - default sizing and stage-count derivation for the pipelined adder
package adder_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_SEG_WIDTH = 8;

    function automatic int calc_stages(input int width, input int seg_width);
        return (seg_width > 0) ? width / seg_width : 1;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// rtl/adder_segment.sv - one SEG_WIDTH-bit ripple stage with registered sum, carry and valid
module adder_segment
    import adder_pkg::*;
#(
    parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic                 valid_in,
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] sum_q,
    output logic                 cout_q,
    output logic                 valid_q
);

    logic [SEG_WIDTH:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SEG_WIDTH{1'b0}}, cin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (adv) begin
            sum_q   <= total[SEG_WIDTH-1:0];
            cout_q  <= total[SEG_WIDTH];
            valid_q <= valid_in;
        end
    end

endmodule

// File: rtl/pipelined_adder_n_bit.sv
// rtl/pipelined_adder_n_bit.sv - carry-segmented pipelined add/sub with valid/ready flow control
module pipelined_adder_n_bit
    import adder_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STAGES = calc_stages(WIDTH, SEG_WIDTH);

    if (SEG_WIDTH < 1 || (WIDTH % SEG_WIDTH) != 0) begin : g_bad_cfg
        $error("pipelined_adder_n_bit: WIDTH must be a positive multiple of SEG_WIDTH");
    end

    logic                 adv;
    logic [WIDTH-1:0]     b_eff;
    logic                 cin_eff;
    logic                 msb_x_q;

    logic [WIDTH-1:0]     skew_a [STAGES];
    logic [WIDTH-1:0]     skew_b [STAGES];
    logic [WIDTH-1:0]     low_q  [STAGES];
    logic [WIDTH-1:0]     acc    [STAGES];

    logic [SEG_WIDTH-1:0] seg_a     [STAGES];
    logic [SEG_WIDTH-1:0] seg_b     [STAGES];
    logic                 seg_cin   [STAGES];
    logic                 seg_vin   [STAGES];
    logic [SEG_WIDTH-1:0] seg_sum   [STAGES];
    logic                 seg_cout  [STAGES];
    logic                 seg_valid [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = sub | cin;

    // Operand skew: skew_x[k] holds the operation that entered k+1 cycles ago,
    // so stage s reads its segment from skew_x[s-1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                skew_a[s] <= '0;
                skew_b[s] <= '0;
                low_q[s]  <= '0;
            end
            msb_x_q <= 1'b0;
        end else if (adv) begin
            skew_a[0] <= a;
            skew_b[0] <= b_eff;
            for (int s = 1; s < STAGES; s++) begin
                skew_a[s] <= skew_a[s-1];
                skew_b[s] <= skew_b[s-1];
                low_q[s]  <= acc[s-1];
            end
            msb_x_q <= seg_a[STAGES-1][SEG_WIDTH-1] ^ seg_b[STAGES-1][SEG_WIDTH-1];
        end
    end

    // Deskew: each stage's output word is the lower segments carried alongside
    // plus the segment it just produced; bits above stay zero.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            acc[s] = (s == 0) ? '0 : low_q[s];
            acc[s][s*SEG_WIDTH +: SEG_WIDTH] = seg_sum[s];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign seg_a[s]   = a[SEG_WIDTH-1:0];
            assign seg_b[s]   = b_eff[SEG_WIDTH-1:0];
            assign seg_cin[s] = cin_eff;
            assign seg_vin[s] = in_valid;
        end else begin : g_rest
            assign seg_a[s]   = skew_a[s-1][s*SEG_WIDTH +: SEG_WIDTH];
            assign seg_b[s]   = skew_b[s-1][s*SEG_WIDTH +: SEG_WIDTH];
            assign seg_cin[s] = seg_cout[s-1];
            assign seg_vin[s] = seg_valid[s-1];
        end

        adder_segment #(
            .SEG_WIDTH(SEG_WIDTH)
        ) u_segment (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv),
            .valid_in(seg_vin[s]),
            .a       (seg_a[s]),
            .b       (seg_b[s]),
            .cin     (seg_cin[s]),
            .sum_q   (seg_sum[s]),
            .cout_q  (seg_cout[s]),
            .valid_q (seg_valid[s])
        );
    end

    // Carry into the MSB is recovered as a^b^sum at that bit.
    assign sum       = acc[STAGES-1];
    assign cout      = seg_cout[STAGES-1];
    assign out_valid = seg_valid[STAGES-1];
    assign overflow  = msb_x_q ^ sum[WIDTH-1] ^ cout;

endmodule

// File: tb/tb_pipelined_adder_n_bit.sv
// tb/tb_pipelined_adder_n_bit.sv - directed self-checking bench for pipelined_adder_n_bit
module tb_pipelined_adder_n_bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic [31:0] a = '0, b = '0, sum;
    logic        out_valid, out_ready = 1'b1, cout, overflow;

    logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, cout2, overflow2;
    logic [15:0] a2 = '0, b2 = '0, sum2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_adder_n_bit #(.WIDTH(32), .SEG_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
    );

    pipelined_adder_n_bit #(.WIDTH(16), .SEG_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(1'b0), .sub(1'b0), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .cout(cout2), .overflow(overflow2)
    );

    task automatic send_and_collect(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                                    input logic ts, output int lat, output logic [31:0] rs,
                                    output logic rc, output logic ro);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rs = sum; rc = cout; ro = overflow;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h want=00000000", sum); end
        total++; if ({cout, overflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {cout, overflow}); end
        total++; if (out_valid2 !== 1'b0 || sum2 !== 16'h0) begin bad++; $display("FAIL reset_dut1 got=%b/%h want=0/0000", out_valid2, sum2); end
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        out_ready = 1'b1;
    endtask

    task automatic test_carry_wrap();
        int lat; logic [31:0] rs; logic rc, ro;
        send_and_collect(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, rs, rc, ro);
        total++; if (lat !== 4) begin bad++; $display("FAIL wrap_latency got=%0d want=4", lat); end
        total++; if (rs !== 32'h0000_0000) begin bad++; $display("FAIL wrap_sum got=%h want=00000000", rs); end
        total++; if ({rc, ro} !== 2'b10) begin bad++; $display("FAIL wrap_cout_ovf got=%b want=10", {rc, ro}); end
    endtask

    task automatic test_signed_overflow();
        int lat; logic [31:0] rs; logic rc, ro;
        send_and_collect(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, rs, rc, ro);
        total++; if (rs !== 32'h8000_0000) begin bad++; $display("FAIL ovf_sum got=%h want=80000000", rs); end
        total++; if ({rc, ro} !== 2'b01) begin bad++; $display("FAIL ovf_cout_ovf got=%b want=01", {rc, ro}); end
    endtask

    task automatic test_subtract();
        int lat; logic [31:0] rs; logic rc, ro;
        send_and_collect(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, lat, rs, rc, ro);
        total++; if (rs !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_sum got=%h want=FFFFFFFE", rs); end
        total++; if ({rc, ro} !== 2'b00) begin bad++; $display("FAIL sub_cout_ovf got=%b want=00", {rc, ro}); end
        send_and_collect(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat, rs, rc, ro);
        total++; if (rs !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sub_neg_sum got=%h want=7FFFFFFF", rs); end
        total++; if ({rc, ro} !== 2'b11) begin bad++; $display("FAIL sub_neg_cout_ovf got=%b want=11", {rc, ro}); end
        send_and_collect(32'h0012_34FF, 32'h00AB_CD01, 1'b1, 1'b0, lat, rs, rc, ro);
        total++; if (rs !== 32'h00BE_0201) begin bad++; $display("FAIL add_cin_sum got=%h want=00BE0201", rs); end
    endtask

    task automatic test_back_to_back();
        int issued = 0, recv = 0, stall_left = 0, extra = 0;
        bit stall_seen = 1'b0;
        logic [31:0] held = '0;
        cin = 1'b0; sub = 1'b0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clk);
            if (out_valid && !stall_seen) begin
                stall_seen = 1'b1; stall_left = 5; held = sum;
            end
            out_ready = (stall_left == 0);
            in_valid  = (issued < 8);
            a = issued; b = issued;
            #1;
            if (stall_left > 0) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
                total++; if (sum !== held || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%b want=%h/1", sum, out_valid, held); end
                stall_left--;
            end
            if (out_valid && out_ready) begin
                total++; if (sum !== 32'(2 * recv)) begin bad++; $display("FAIL b2b_sum[%0d] got=%h want=%h", recv, sum, 32'(2 * recv)); end
                recv++;
            end
            if (in_valid && in_ready) issued++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (recv !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", recv); end
        total++; if (!stall_seen) begin bad++; $display("FAIL b2b_stall_seen got=0 want=1"); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL b2b_duplicates got=%0d want=0", extra); end
    endtask

    task automatic test_async_reset();
        int extra = 0;
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 32'(10 + i); b = 32'h1; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || sum !== 32'd11) begin bad++; $display("FAIL arst_first got=%b/%h want=1/0000000b", out_valid, sum); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", out_valid); end
        total++; if (sum !== 32'h0 || cout !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL arst_outputs got=%h/%b/%b want=0/0/0", sum, cout, overflow); end
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b want=1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL arst_ghosts got=%0d want=0", extra); end
    endtask

    task automatic test_single_stage();
        @(negedge clk);
        a2 = 16'h1234; b2 = 16'h4321; in_valid2 = 1'b1; out_ready2 = 1'b1;
        total++; if (out_valid2 !== 1'b0) begin bad++; $display("FAIL s1_pre_valid got=%b want=0", out_valid2); end
        @(negedge clk);
        in_valid2 = 1'b0;
        total++; if (out_valid2 !== 1'b1 || sum2 !== 16'h5555) begin bad++; $display("FAIL s1_result got=%b/%h want=1/5555", out_valid2, sum2); end
        total++; if ({cout2, overflow2} !== 2'b00) begin bad++; $display("FAIL s1_flags got=%b want=00", {cout2, overflow2}); end
        @(negedge clk);
        total++; if (out_valid2 !== 1'b0) begin bad++; $display("FAIL s1_bubble got=%b want=0", out_valid2); end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_signed_overflow();
        test_subtract();
        test_back_to_back();
        test_async_reset();
        test_single_stage();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
